// File: rtl/viterbi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : viterbi_pkg
// Brief   : Code constants and FSM states shared by the K=7 encoder and decoder
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package viterbi_pkg;

  localparam int K        = 7;
  localparam int TAIL_LEN = K - 1;

  // w[K-1] is the current bit, so these read MSB-first as the octal generators
  localparam logic [K-1:0] G0 = 7'o171;
  localparam logic [K-1:0] G1 = 7'o133;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  function automatic logic parity_tap(input logic [K-1:0] window,
                                      input logic [K-1:0] poly);
    return ^(window & poly);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : conv_enc_core
// Brief   : K=7 shift register and generator parity; sym is combinational
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       data_bit,
  output logic [1:0] sym
);

  logic [K-2:0] r_sreg;
  logic [K-1:0] w_window;

  // Newest past bit enters at the top so the window reads {current, newest..oldest}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (clr) begin
      r_sreg <= '0;
    end else if (en) begin
      r_sreg <= {data_bit, r_sreg[K-2:1]};
    end
  end

  assign w_window = {data_bit, r_sreg};
  assign sym      = {parity_tap(w_window, G0), parity_tap(w_window, G1)};

endmodule
`default_nettype wire

// File: rtl/conv_encoder_k7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : conv_encoder_k7
// Brief   : Frame-based rate-1/2 K=7 encoder with zero tail and valid/ready I/O
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module conv_encoder_k7 #(
  parameter int FRAME_LEN = 8,
  parameter int K         = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_sop,
  output logic       sym_eop,
  output logic       busy
);

  import viterbi_pkg::enc_state_t;
  import viterbi_pkg::IDLE;
  import viterbi_pkg::DATA;
  import viterbi_pkg::TAIL;
  import viterbi_pkg::TAIL_LEN;

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(TAIL_LEN + 1);

  localparam logic [CW-1:0] c_last_bit  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] c_last_tail = TW'(TAIL_LEN - 1);
  localparam logic [TW-1:0] c_eop_tail  = TW'(K - 2);

  if (K != viterbi_pkg::K) begin : g_k_check
    $error("conv_encoder_k7: K must equal viterbi_pkg::K");
  end

  if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_len_check
    $error("conv_encoder_k7: FRAME_LEN out of range 1..65535");
  end

  enc_state_t    r_state,    w_state_nxt;
  logic [CW-1:0] r_bit_cnt,  w_bit_cnt_nxt;
  logic [TW-1:0] r_tail_cnt, w_tail_cnt_nxt;
  logic          r_first,    w_first_nxt;

  logic          r_sym_valid;
  logic [1:0]    r_sym_out;
  logic          r_sym_sop;
  logic          r_sym_eop;

  logic          w_slot_free;
  logic          w_in_ready;
  logic          w_core_en;
  logic          w_core_clr;
  logic          w_core_bit;
  logic [1:0]    w_core_sym;
  logic          w_load;
  logic          w_load_sop;
  logic          w_load_eop;

  assign w_slot_free = !r_sym_valid || sym_ready;

  conv_enc_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_core_en),
    .clr      (w_core_clr),
    .data_bit (w_core_bit),
    .sym      (w_core_sym)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tail_cnt <= w_tail_cnt_nxt;
      r_first    <= w_first_nxt;
    end
  end

  // Every symbol-producing step advances the core and loads the output register together
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tail_cnt_nxt = r_tail_cnt;
    w_first_nxt    = r_first;
    w_in_ready     = 1'b0;
    w_core_en      = 1'b0;
    w_core_clr     = 1'b0;
    w_core_bit     = 1'b0;
    w_load         = 1'b0;
    w_load_sop     = 1'b0;
    w_load_eop     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_core_clr    = 1'b1;
          w_bit_cnt_nxt = '0;
          w_first_nxt   = 1'b1;
          w_state_nxt   = DATA;
        end
      end

      DATA: begin
        w_in_ready = w_slot_free;
        if (in_valid && w_slot_free) begin
          w_core_en     = 1'b1;
          w_core_bit    = in_bit;
          w_load        = 1'b1;
          w_load_sop    = r_first;
          w_first_nxt   = 1'b0;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_tail_cnt_nxt = '0;
            w_state_nxt    = TAIL;
          end
        end
      end

      TAIL: begin
        if (w_slot_free) begin
          w_core_en      = 1'b1;
          w_load         = 1'b1;
          w_load_eop     = (r_tail_cnt == c_eop_tail);
          w_tail_cnt_nxt = r_tail_cnt + 1'b1;
          if (r_tail_cnt == c_last_tail) begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output register: a load may coincide with the consumption of the previous symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_valid <= 1'b0;
      r_sym_out   <= '0;
      r_sym_sop   <= 1'b0;
      r_sym_eop   <= 1'b0;
    end else if (w_load) begin
      r_sym_valid <= 1'b1;
      r_sym_out   <= w_core_sym;
      r_sym_sop   <= w_load_sop;
      r_sym_eop   <= w_load_eop;
    end else if (sym_ready) begin
      r_sym_valid <= 1'b0;
      r_sym_sop   <= 1'b0;
      r_sym_eop   <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign sym_out   = r_sym_out;
  assign sym_valid = r_sym_valid;
  assign sym_sop   = r_sym_sop;
  assign sym_eop   = r_sym_eop;
  assign busy      = (r_state != IDLE) || r_sym_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_k7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_conv_encoder_k7
// Brief   : Scoreboard bench for conv_encoder_k7 against a tap-delay reference
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_conv_encoder_k7;

  localparam int FL   = 8;
  localparam int TL   = 6;
  localparam int NSYM = FL + TL;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       sym_sop;
  logic       sym_eop;
  logic       busy;

  conv_encoder_k7 #(.FRAME_LEN(FL), .K(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_sop   (sym_sop),
    .sym_eop   (sym_eop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int sym_seen = 0;
  int sop_seen = 0;
  int ready_mode = 0;
  int valid_pct  = 100;

  logic [3:0] expq [$];   // {sop, eop, g0, g1}
  logic       bitq [$];
  logic [1:0] impulse_gold [NSYM] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11,
                                      2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  int         g0_delays [5] = '{0, 1, 2, 3, 6};   // 171 octal
  int         g1_delays [5] = '{0, 2, 3, 5, 6};   // 133 octal

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each output is the XOR of the input sequence at the generator's delays; zeros outside the frame
  task automatic push_frame(input logic [FL-1:0] bits);
    logic g0, g1;
    int   idx;
    for (int i = 0; i < FL; i++) bitq.push_back(bits[i]);
    for (int n = 0; n < NSYM; n++) begin
      g0 = 1'b0;
      g1 = 1'b0;
      for (int t = 0; t < 5; t++) begin
        idx = n - g0_delays[t];
        if (idx >= 0 && idx < FL) g0 ^= bits[idx];
        idx = n - g1_delays[t];
        if (idx >= 0 && idx < FL) g1 ^= bits[idx];
      end
      expq.push_back({(n == 0), (n == NSYM - 1), g0, g1});
    end
  endtask

  task automatic push_impulse();
    for (int i = 0; i < FL; i++) bitq.push_back(i == 0);
    for (int n = 0; n < NSYM; n++)
      expq.push_back({(n == 0), (n == NSYM - 1), impulse_gold[n]});
  endtask

  // Driver: owns in_valid/in_bit/sym_ready; pops a bit when the handshake will complete
  logic tgl = 1'b0;
  initial begin
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    sym_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready && bitq.size() > 0) void'(bitq.pop_front());
      @(posedge clk);
      #1;
      tgl = ~tgl;
      if (bitq.size() > 0) begin
        in_valid = ($urandom_range(0, 99) < valid_pct);
        in_bit   = bitq[0];
      end else begin
        in_valid = 1'b0;
      end
      case (ready_mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = tgl;
        default: sym_ready = $urandom_range(0, 1);
      endcase
    end
  end

  // Monitor: compares each consumed symbol and checks hold-stability while stalled
  logic       stall_prev = 1'b0;
  logic [3:0] held = '0;
  logic [3:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_stable", {sym_valid, sym_sop, sym_eop, sym_out}, {1'b1, held});
      if (sym_valid && sym_ready) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_symbol: got %0h expected none", {sym_sop, sym_eop, sym_out});
        end else begin
          e = expq.pop_front();
          check("symbol", {sym_sop, sym_eop, sym_out}, e);
        end
        sym_seen++;
        if (sym_sop) sop_seen++;
      end
      stall_prev = sym_valid && !sym_ready;
      held       = {sym_sop, sym_eop, sym_out};
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("idle_timeout", (n < 2000), 1);
  endtask

  task automatic start_frame();
    wait_idle();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", (n < 4000), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sym_valid"}, sym_valid, 0);
    check({tag, "_sym_out"},   sym_out,   0);
    check({tag, "_sym_sop"},   sym_sop,   0);
    check({tag, "_sym_eop"},   sym_eop,   0);
    check({tag, "_in_ready"},  in_ready,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Impulse and all-ones, full throughput
    push_impulse();
    start_frame();
    drain();
    push_frame({FL{1'b1}});
    start_frame();
    drain();

    // Backpressure: toggling ready, then random ready with a stray mid-frame start
    ready_mode = 1;
    valid_pct  = 50;
    push_impulse();
    start_frame();
    drain();
    push_frame({FL{1'b1}});
    start_frame();
    drain();
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      valid_pct = $urandom_range(30, 100);
      push_frame(FL'($urandom));
      start_frame();
      repeat (4) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      drain();
    end

    // Back-to-back frames with start held high
    ready_mode = 0;
    valid_pct  = 100;
    for (int f = 0; f < 3; f++) push_frame(FL'($urandom));
    wait_idle();
    base = sop_seen;
    @(posedge clk);
    #2 start = 1'b1;
    n = 0;
    while (sop_seen < base + 3 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("b2b_timeout", (n < 2000), 1);
    #2 start = 1'b0;
    drain();
    check("b2b_frames", sop_seen - base, 3);

    // Reset mid-frame, then a clean impulse frame
    push_frame(FL'($urandom));
    base = sym_seen;
    start_frame();
    n = 0;
    while (sym_seen < base + 3 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("rst_wait_timeout", (n < 2000), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    expq.delete();
    bitq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    push_impulse();
    start_frame();
    drain();

    check("final_queue_empty", expq.size(), 0);
    check("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
